// File: rtl/dn_arbiter.sv
// Three-way download-port arbiter: whole sessions are granted round-robin between
// ioctl, cmd loader and debug, and writes inside a session are paced WR_GAP cycles apart.
module dn_arbiter #(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 8,
  parameter int WR_GAP = 4
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic [2:0]            src_go,
  input  logic [2:0]            src_wr,
  input  logic [3*ADDR_W-1:0]   src_addr,
  input  logic [3*DATA_W-1:0]   src_data,
  output logic [2:0]            src_wait,
  output logic                  dn_go,
  output logic                  dn_wr,
  output logic [ADDR_W-1:0]     dn_addr,
  output logic [DATA_W-1:0]     dn_data,
  output logic [1:0]            owner,
  output logic                  drop_err
);

  typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;

  localparam logic [3:0] GAP_LOAD = 4'(WR_GAP - 1);
  localparam logic [1:0] NO_OWNER = 2'd3;

  state_t              state;
  logic [3:0]          cnt;
  logic [1:0]          last;

  logic                cnt_zero;
  logic [2:0]          owner_mask;
  logic                owner_go;
  logic                owner_wr;
  logic                accept;
  logic                illegal;
  logic [ADDR_W-1:0]   owner_addr;
  logic [DATA_W-1:0]   owner_data;
  logic [1:0]          grant_idx;
  logic                grant_found;

  // owner==3 shifts the single bit out, so "no owner" yields an empty mask.
  assign owner_mask = 3'b001 << owner;
  assign cnt_zero   = (cnt == 4'd0);
  assign owner_go   = |(src_go & owner_mask);
  assign owner_wr   = |(src_wr & owner_mask);
  assign accept     = (state == OWN) && owner_wr && cnt_zero;
  assign illegal    = |(src_wr & ~(accept ? owner_mask : 3'b000));

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    owner_addr = '0;
    owner_data = '0;
    for (int n = 0; n < 3; n++) begin
      if (owner_mask[n]) begin
        owner_addr = src_addr[n*ADDR_W +: ADDR_W];
        owner_data = src_data[n*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin scan starting just after the previous grantee.
  always_comb begin
    grant_idx   = 2'd0;
    grant_found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (!grant_found && src_go[(int'(last) + k) % 3]) begin
        grant_idx   = 2'((int'(last) + k) % 3);
        grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    src_wait = '0;
    for (int n = 0; n < 3; n++) begin
      src_wait[n] = src_go[n] & ~((state == OWN) && (owner == 2'(n)) && cnt_zero);
    end
  end

  always_ff @(posedge clk_sys) begin
    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state    <= IDLE;
      dn_go    <= 1'b0;
      dn_wr    <= 1'b0;
      dn_addr  <= '0;
      dn_data  <= '0;
      owner    <= NO_OWNER;
      cnt      <= 4'd0;
      last     <= 2'd2;
      drop_err <= 1'b0;
    end else begin
      dn_wr <= accept;
      if (accept) begin
        dn_addr <= owner_addr;
        dn_data <= owner_data;
        cnt     <= GAP_LOAD;
      end else if (!cnt_zero) begin
        cnt <= cnt - 4'd1;
      end

      if (illegal) drop_err <= 1'b1;

      case (state)
        IDLE: begin
          if (grant_found) begin
            state <= OWN;
            owner <= grant_idx;
            last  <= grant_idx;
            dn_go <= 1'b1;
          end
        end
        OWN: begin
          // Release decision uses the pre-write counter, so a final write on the
          // falling-go cycle still closes the session immediately.
          if (!owner_go) begin
            if (cnt_zero) begin
              state <= IDLE;
              owner <= NO_OWNER;
              dn_go <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (cnt_zero) begin
            state <= IDLE;
            owner <= NO_OWNER;
            dn_go <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          owner <= NO_OWNER;
          dn_go <= 1'b0;
        end
      endcase
    end
  end

endmodule
